// File: rtl/saturn_bus_sequencer.sv
// Saturn bus sequencer: arbitrates two requesters (A = control unit,
// B = debugger). Each granted request becomes a command/address/data nibble
// stream on the 4-phase Saturn nibble bus.
module saturn_bus_sequencer #(
  parameter logic [3:0] CMD_PC_READ  = 4'h2,
  parameter logic [3:0] CMD_DP_READ  = 4'h3,
  parameter logic [3:0] CMD_DP_WRITE = 4'h5,
  parameter logic [3:0] CMD_LOAD_PC  = 4'h6,
  parameter logic [3:0] CMD_LOAD_DP  = 4'h7
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [3:0]  i_phases,
  input  logic        i_a_req,
  input  logic [1:0]  i_a_type,
  input  logic [19:0] i_a_addr,
  input  logic [3:0]  i_a_len,
  input  logic [3:0]  i_a_wdata,
  output logic        o_a_wack,
  output logic        o_a_done,
  input  logic        i_b_req,
  input  logic [1:0]  i_b_type,
  input  logic [19:0] i_b_addr,
  input  logic [3:0]  i_b_len,
  input  logic [3:0]  i_b_wdata,
  output logic        o_b_wack,
  output logic        o_b_done,
  output logic        o_rd_valid,
  output logic [3:0]  o_rd_nibble,
  output logic        o_rd_owner,
  output logic        o_bus_clk_en,
  output logic        o_bus_is_data,
  output logic [3:0]  o_bus_nibble_out,
  input  logic [3:0]  i_bus_nibble_in,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ADDR = 3'd2,
    S_XCMD = 3'd3,
    S_XFER = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_r;
  state_t      eff_state_s;
  logic        last_grant_r;   // 0 = A, 1 = B
  logic        owner_r;
  logic        rd_pend_r;
  logic        wr_pend_r;
  logic [1:0]  type_r;
  logic [3:0]  len_r;
  logic [19:0] addr_sh_r;
  logic [2:0]  addr_cnt_r;
  logic [3:0]  xfer_cnt_r;

  logic        grant_s;
  logic        pick_b_s;
  logic [1:0]  sel_type_s;
  logic [19:0] sel_addr_s;
  logic [3:0]  sel_len_s;
  logic [1:0]  cur_type_s;
  logic [3:0]  cur_len_s;
  logic [3:0]  cmd_s;
  logic [3:0]  load_cmd_s;
  logic [3:0]  wdata_s;
  logic        is_write_s;

  // Arbitration and the "effective" state: on a grant slot the first nibble
  // is emitted immediately, so the granted request's fields are used directly.
  always_comb begin
    grant_s     = 1'b0;
    pick_b_s    = 1'b0;
    sel_type_s  = 2'b00;
    sel_addr_s  = 20'h00000;
    sel_len_s   = 4'h0;
    eff_state_s = state_r;
    cur_type_s  = type_r;
    cur_len_s   = len_r;
    if (state_r == S_IDLE) begin
      grant_s = i_a_req | i_b_req;
    end else begin
      grant_s = 1'b0;
    end
    // Tie goes to whichever requester was not granted last.
    pick_b_s = i_b_req & (~i_a_req | ~last_grant_r);
    if (pick_b_s) begin
      sel_type_s = i_b_type;
      sel_addr_s = i_b_addr;
      sel_len_s  = i_b_len;
    end else begin
      sel_type_s = i_a_type;
      sel_addr_s = i_a_addr;
      sel_len_s  = i_a_len;
    end
    if (grant_s) begin
      eff_state_s = (sel_type_s == 2'b00) ? S_XCMD : S_LOAD;
      cur_type_s  = sel_type_s;
      cur_len_s   = sel_len_s;
    end else begin
      eff_state_s = state_r;
      cur_type_s  = type_r;
      cur_len_s   = len_r;
    end
    case (cur_type_s)
      2'b00:   cmd_s = CMD_PC_READ;
      2'b01:   cmd_s = CMD_PC_READ;
      2'b10:   cmd_s = CMD_DP_READ;
      2'b11:   cmd_s = CMD_DP_WRITE;
      default: cmd_s = CMD_PC_READ;
    endcase
    if (cur_type_s == 2'b01) begin
      load_cmd_s = CMD_LOAD_PC;
    end else begin
      load_cmd_s = CMD_LOAD_DP;
    end
    if (owner_r) begin
      wdata_s = i_b_wdata;
    end else begin
      wdata_s = i_a_wdata;
    end
    is_write_s = (type_r == 2'b11);
  end

  // Sequencer FSM and all registered outputs, advanced only on enabled edges.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r          <= S_IDLE;
      last_grant_r     <= 1'b1;
      owner_r          <= 1'b0;
      rd_pend_r        <= 1'b0;
      wr_pend_r        <= 1'b0;
      type_r           <= 2'b00;
      len_r            <= 4'h0;
      addr_sh_r        <= 20'h00000;
      addr_cnt_r       <= 3'd0;
      xfer_cnt_r       <= 4'h0;
      o_a_wack         <= 1'b0;
      o_a_done         <= 1'b0;
      o_b_wack         <= 1'b0;
      o_b_done         <= 1'b0;
      o_rd_valid       <= 1'b0;
      o_rd_nibble      <= 4'h0;
      o_rd_owner       <= 1'b0;
      o_bus_clk_en     <= 1'b0;
      o_bus_is_data    <= 1'b0;
      o_bus_nibble_out <= 4'h0;
      o_busy           <= 1'b0;
    end else if (i_clk_en) begin
      o_a_wack   <= 1'b0;
      o_b_wack   <= 1'b0;
      o_a_done   <= 1'b0;
      o_b_done   <= 1'b0;
      o_rd_valid <= 1'b0;
      case (i_phases)
        4'b0001: begin
          if (grant_s) begin
            type_r       <= sel_type_s;
            len_r        <= sel_len_s;
            addr_sh_r    <= sel_addr_s;
            owner_r      <= pick_b_s;
            last_grant_r <= pick_b_s;
            o_busy       <= 1'b1;
          end
          case (eff_state_s)
            S_LOAD: begin
              o_bus_clk_en     <= 1'b1;
              o_bus_is_data    <= 1'b0;
              o_bus_nibble_out <= load_cmd_s;
              addr_cnt_r       <= 3'd0;
              state_r          <= S_ADDR;
            end
            S_ADDR: begin
              o_bus_clk_en     <= 1'b1;
              o_bus_is_data    <= 1'b0;
              o_bus_nibble_out <= addr_sh_r[3:0];
              addr_sh_r        <= {4'h0, addr_sh_r[19:4]};
              if (addr_cnt_r == 3'd4) begin
                state_r <= S_XCMD;
              end else begin
                addr_cnt_r <= addr_cnt_r + 3'd1;
              end
            end
            S_XCMD: begin
              o_bus_clk_en     <= 1'b1;
              o_bus_is_data    <= 1'b0;
              o_bus_nibble_out <= cmd_s;
              xfer_cnt_r       <= cur_len_s;
              state_r          <= S_XFER;
            end
            S_XFER: begin
              o_bus_clk_en     <= 1'b1;
              o_bus_is_data    <= 1'b1;
              o_bus_nibble_out <= is_write_s ? wdata_s : 4'h0;
              wr_pend_r        <= is_write_s;
              rd_pend_r        <= ~is_write_s;
              // Stop at zero rather than wrapping so len=15 yields 16 slots.
              if (xfer_cnt_r == 4'h0) begin
                state_r <= S_DONE;
              end else begin
                xfer_cnt_r <= xfer_cnt_r - 4'h1;
              end
            end
            default: begin
            end
          endcase
        end
        4'b0010: begin
          o_bus_clk_en <= 1'b0;
          if (wr_pend_r) begin
            o_a_wack <= ~owner_r;
            o_b_wack <= owner_r;
          end
          wr_pend_r <= 1'b0;
        end
        4'b0100: begin
          if (rd_pend_r) begin
            o_rd_nibble <= i_bus_nibble_in;
            o_rd_valid  <= 1'b1;
            o_rd_owner  <= owner_r;
          end
          rd_pend_r <= 1'b0;
        end
        4'b1000: begin
          if (state_r == S_DONE) begin
            o_a_done <= ~owner_r;
            o_b_done <= owner_r;
            o_busy   <= 1'b0;
            state_r  <= S_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_bus_sequencer.sv
// Testbench for saturn_bus_sequencer: requester queues drive randomized
// transactions; a transaction-level model predicts the nibble stream, pulses
// and arbitration order.
`timescale 1ns/1ps
module tb_saturn_bus_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset, i_clk_en;
  logic [3:0]  i_phases;
  logic        i_a_req, i_b_req;
  logic [1:0]  i_a_type, i_b_type;
  logic [19:0] i_a_addr, i_b_addr;
  logic [3:0]  i_a_len, i_b_len, i_a_wdata, i_b_wdata;
  logic        o_a_wack, o_a_done, o_b_wack, o_b_done;
  logic        o_rd_valid, o_rd_owner, o_bus_clk_en, o_bus_is_data, o_busy;
  logic [3:0]  o_rd_nibble, o_bus_nibble_out, i_bus_nibble_in;
  logic [16:0] outs_w;

  saturn_bus_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_phases(i_phases),
    .i_a_req(i_a_req), .i_a_type(i_a_type), .i_a_addr(i_a_addr), .i_a_len(i_a_len),
    .i_a_wdata(i_a_wdata), .o_a_wack(o_a_wack), .o_a_done(o_a_done),
    .i_b_req(i_b_req), .i_b_type(i_b_type), .i_b_addr(i_b_addr), .i_b_len(i_b_len),
    .i_b_wdata(i_b_wdata), .o_b_wack(o_b_wack), .o_b_done(o_b_done),
    .o_rd_valid(o_rd_valid), .o_rd_nibble(o_rd_nibble), .o_rd_owner(o_rd_owner),
    .o_bus_clk_en(o_bus_clk_en), .o_bus_is_data(o_bus_is_data),
    .o_bus_nibble_out(o_bus_nibble_out), .i_bus_nibble_in(i_bus_nibble_in),
    .o_busy(o_busy)
  );

  assign outs_w = {o_a_wack, o_b_wack, o_a_done, o_b_done, o_rd_valid, o_rd_nibble,
                   o_rd_owner, o_bus_clk_en, o_bus_is_data, o_bus_nibble_out, o_busy};

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [1:0]  typ;
    logic [19:0] addr;
    logic [3:0]  len;
    logic [63:0] wd;
  } txn_t;

  txn_t pqa[$];
  txn_t pqb[$];
  int checks = 0, failures = 0;

  // reference model state
  bit         m_active, m_owner, m_last, rd_pend, wr_pend;
  txn_t       m_txn;
  logic [5:0] exp_q[$];   // {dont_care, is_data, nibble}
  int         m_popped;
  // observed statistics
  int done_cnt[2], rd_cnt[2], wack_cnt[2];
  int done_order[$];
  int obs_slots, last_slots, widx_a, widx_b;
  logic [3:0] last_data, first_nib;
  // stimulus control
  int ph_idx = 0, en_pct = 100, en_low_left = 0;
  logic [16:0] snap = 17'd0;

  task automatic model_reset();
    m_active = 1'b0; m_last = 1'b1; rd_pend = 1'b0; wr_pend = 1'b0;
    exp_q.delete(); m_popped = 0; obs_slots = 0; widx_a = 0; widx_b = 0;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin done_cnt[k] = 0; rd_cnt[k] = 0; wack_cnt[k] = 0; end
    done_order.delete(); last_slots = 0;
  endtask

  task automatic drive_reqs();
    i_a_req = (pqa.size() != 0); i_b_req = (pqb.size() != 0);
    if (pqa.size() != 0) begin
      i_a_type = pqa[0].typ; i_a_addr = pqa[0].addr; i_a_len = pqa[0].len;
      i_a_wdata = pqa[0].wd[(widx_a & 15) * 4 +: 4];
    end else begin
      i_a_type = 2'b00; i_a_addr = 20'h0; i_a_len = 4'h0; i_a_wdata = 4'h0;
    end
    if (pqb.size() != 0) begin
      i_b_type = pqb[0].typ; i_b_addr = pqb[0].addr; i_b_len = pqb[0].len;
      i_b_wdata = pqb[0].wd[(widx_b & 15) * 4 +: 4];
    end else begin
      i_b_type = 2'b00; i_b_addr = 20'h0; i_b_len = 4'h0; i_b_wdata = 4'h0;
    end
  endtask

  // Expected nibble list from the transaction's type/addr/len.
  task automatic start_txn();
    txn_t t;
    bit own;
    own = i_b_req && (!i_a_req || !m_last);
    t = own ? pqb[0] : pqa[0];
    m_owner = own; m_txn = t; m_active = 1'b1; m_popped = 0; exp_q.delete();
    if (t.typ == 2'b00) begin
      exp_q.push_back({2'b00, 4'h2});
    end else begin
      exp_q.push_back({2'b00, (t.typ == 2'b01) ? 4'h6 : 4'h7});
      for (int k = 0; k < 5; k++) exp_q.push_back({2'b00, t.addr[k*4 +: 4]});
      exp_q.push_back({2'b00, (t.typ == 2'b01) ? 4'h2 : (t.typ == 2'b10) ? 4'h3 : 4'h5});
    end
    for (int k = 0; k <= int'(t.len); k++)
      exp_q.push_back((t.typ == 2'b11) ? {2'b01, t.wd[k*4 +: 4]} : {2'b11, 4'h0});
  endtask

  // One clock: observe at negedge, check against the model, then drive next inputs.
  task automatic step();
    logic [3:0] pph;
    logic       pen;
    logic [4:0] ep;
    logic [5:0] e;
    bit         fin;
    @(negedge i_clk);
    pen = i_clk_en; pph = i_phases;
    if (i_reset) begin
      checks++;
      if (outs_w !== 17'd0) begin failures++; $display("FAIL reset_hold got=%h want=0", outs_w); end
    end else if (!pen) begin
      checks++;
      if (outs_w !== snap) begin failures++; $display("FAIL freeze got=%h want=%h", outs_w, snap); end
    end else begin
      ep = 5'd0; fin = 1'b0;
      if (pph == 4'b0001) begin
        if (!m_active && (i_a_req || i_b_req)) start_txn();
        if (m_active && exp_q.size() != 0) begin
          e = exp_q.pop_front(); m_popped++;
          checks++;
          if (o_bus_clk_en !== 1'b1 || o_bus_is_data !== e[4] || (!e[5] && o_bus_nibble_out !== e[3:0])) begin
            failures++;
            $display("FAIL nibble got=en%b d%b %h want=en1 d%b %h", o_bus_clk_en, o_bus_is_data, o_bus_nibble_out, e[4], e[3:0]);
          end
          if (e[4]) begin
            if (m_txn.typ == 2'b11) wr_pend = 1'b1; else rd_pend = 1'b1;
          end
        end else begin
          checks++;
          if (o_bus_clk_en !== 1'b0) begin failures++; $display("FAIL idle_strobe got=%b want=0", o_bus_clk_en); end
        end
      end
      if (pph == 4'b0010) begin
        checks++;
        if (o_bus_clk_en !== 1'b0) begin failures++; $display("FAIL strobe_clear got=%b want=0", o_bus_clk_en); end
        if (wr_pend) begin ep[4] = !m_owner; ep[3] = m_owner; end
        wr_pend = 1'b0;
      end
      if (pph == 4'b0100) begin
        if (rd_pend) begin
          ep[0] = 1'b1;
          checks++;
          if ({o_rd_owner, o_rd_nibble} !== {m_owner, i_bus_nibble_in}) begin
            failures++;
            $display("FAIL rd_data got=%b/%h want=%b/%h", o_rd_owner, o_rd_nibble, m_owner, i_bus_nibble_in);
          end
        end
        rd_pend = 1'b0;
      end
      if (pph == 4'b1000 && m_active && exp_q.size() == 0) begin
        ep[2] = !m_owner; ep[1] = m_owner; fin = 1'b1;
      end
      checks++;
      if ({o_a_wack, o_b_wack, o_a_done, o_b_done, o_rd_valid} !== ep) begin
        failures++;
        $display("FAIL pulses got=%b want=%b phase=%b", {o_a_wack, o_b_wack, o_a_done, o_b_done, o_rd_valid}, ep, pph);
      end
      if (fin) begin m_active = 1'b0; m_last = m_owner; end
      checks++;
      if (o_busy !== m_active) begin failures++; $display("FAIL busy got=%b want=%b", o_busy, m_active); end
      // statistics and requester reaction, from observed outputs
      if (pph == 4'b0001 && o_busy === 1'b1) begin
        obs_slots++;
        if (obs_slots == 1) first_nib = o_bus_nibble_out;
      end
      if (pph == 4'b0001 && o_bus_clk_en === 1'b1 && o_bus_is_data === 1'b1) last_data = o_bus_nibble_out;
      if (o_rd_valid === 1'b1) rd_cnt[o_rd_owner]++;
      if (o_a_wack === 1'b1) begin wack_cnt[0]++; widx_a++; end
      if (o_b_wack === 1'b1) begin wack_cnt[1]++; widx_b++; end
      if (o_a_done === 1'b1) begin
        done_cnt[0]++; done_order.push_back(0); last_slots = obs_slots; obs_slots = 0; widx_a = 0;
        if (pqa.size() != 0) void'(pqa.pop_front());
      end
      if (o_b_done === 1'b1) begin
        done_cnt[1]++; done_order.push_back(1); last_slots = obs_slots; obs_slots = 0; widx_b = 0;
        if (pqb.size() != 0) void'(pqb.pop_front());
      end
    end
    if (pen) ph_idx = (ph_idx + 1) % 4;
    i_phases = 4'b0001 << ph_idx;
    if (en_low_left > 0) begin i_clk_en = 1'b0; en_low_left--; end
    else i_clk_en = ($urandom_range(99) < en_pct);
    i_bus_nibble_in = 4'($urandom);
    drive_reqs();
    snap = outs_w;
  endtask

  task automatic run_until_idle(input int max_cyc, input string name);
    int n = 0;
    while ((pqa.size() != 0 || pqb.size() != 0 || m_active) && n < max_cyc) begin step(); n++; end
    checks++;
    if (n >= max_cyc) begin failures++; $display("FAIL %s timeout got=%0d cycles want<%0d", name, n, max_cyc); end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    model_reset();
    step(); step();
    i_reset = 1'b0;
  endtask

  function automatic txn_t mk(input logic [1:0] typ, input logic [19:0] addr, input logic [3:0] len, input logic [63:0] wd);
    txn_t t;
    t.typ = typ; t.addr = addr; t.len = len; t.wd = wd;
    return t;
  endfunction

  task automatic test_reset();
    #2 i_reset = 1'b1;
    #1 checks++;
    if (outs_w !== 17'd0) begin failures++; $display("FAIL reset_outputs got=%h want=0", outs_w); end
    model_reset();
    step(); step(); step();
    i_reset = 1'b0;
  endtask

  task automatic test_load_read();
    clear_stats();
    pqa.push_back(mk(2'b01, 20'h12345, 4'd2, 64'h0));
    drive_reqs();
    run_until_idle(300, "load_read");
    checks++;
    if (rd_cnt[0] !== 3 || rd_cnt[1] !== 0) begin failures++; $display("FAIL load_read_rd got=%0d/%0d want=3/0", rd_cnt[0], rd_cnt[1]); end
    checks++;
    if (done_cnt[0] !== 1 || last_slots !== 10) begin failures++; $display("FAIL load_read_done got=%0d slots=%0d want=1 slots=10", done_cnt[0], last_slots); end
  endtask

  task automatic test_arbitration();
    int exp_ord[4] = '{0, 1, 0, 1};
    do_reset();
    clear_stats();
    for (int k = 0; k < 2; k++) begin
      pqa.push_back(mk(2'($urandom), 20'($urandom), 4'($urandom_range(3)), {$urandom, $urandom}));
      pqb.push_back(mk(2'($urandom), 20'($urandom), 4'($urandom_range(3)), {$urandom, $urandom}));
    end
    drive_reqs();
    run_until_idle(600, "arbitration");
    checks++;
    if (done_order.size() != 4) begin
      failures++; $display("FAIL arb_count got=%0d want=4", done_order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (done_order[k] != exp_ord[k]) begin failures++; $display("FAIL arb_order[%0d] got=%0d want=%0d", k, done_order[k], exp_ord[k]); end
      end
    end
  endtask

  task automatic test_write_b();
    clear_stats();
    pqb.push_back(mk(2'b11, 20'h00000, 4'd0, 64'hC));
    drive_reqs();
    run_until_idle(300, "write_b");
    checks++;
    if (wack_cnt[1] !== 1 || wack_cnt[0] !== 0 || done_cnt[1] !== 1) begin
      failures++; $display("FAIL write_b_pulses got=wack%0d done%0d want=wack1 done1", wack_cnt[1], done_cnt[1]);
    end
    checks++;
    if (last_data !== 4'hC || last_slots !== 8) begin failures++; $display("FAIL write_b_data got=%h slots=%0d want=c slots=8", last_data, last_slots); end
  endtask

  task automatic test_long_read();
    clear_stats();
    pqa.push_back(mk(2'b00, 20'($urandom), 4'd15, 64'h0));
    drive_reqs();
    run_until_idle(600, "long_read");
    checks++;
    if (rd_cnt[0] !== 16 || done_cnt[0] !== 1 || last_slots !== 17) begin
      failures++; $display("FAIL long_read got=rd%0d done%0d slots%0d want=rd16 done1 slots17", rd_cnt[0], done_cnt[0], last_slots);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_stats();
    pqa.push_back(mk(2'b01, 20'($urandom), 4'($urandom_range(4)), 64'h0));
    drive_reqs();
    while (!(m_active && m_popped == 5) && n < 200) begin step(); n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL reset_mid_reach timeout got=%0d want<200", n); end
    #2 i_reset = 1'b1;
    #1 checks++;
    if (outs_w !== 17'd0) begin failures++; $display("FAIL reset_mid_async got=%h want=0", outs_w); end
    model_reset();
    step(); step();
    i_reset = 1'b0;
    run_until_idle(300, "reset_mid");
    checks++;
    if (done_cnt[0] !== 1 || first_nib !== 4'h6) begin
      failures++; $display("FAIL reset_mid got=done%0d first=%h want=done1 first=6", done_cnt[0], first_nib);
    end
  endtask

  task automatic test_freeze();
    int n = 0;
    clear_stats();
    pqb.push_back(mk(2'b00, 20'h0, 4'd15, 64'h0));
    drive_reqs();
    while (rd_cnt[1] < 5 && n < 300) begin step(); n++; end
    en_low_left = 10;
    repeat (12) step();
    run_until_idle(600, "freeze");
    checks++;
    if (rd_cnt[1] !== 16 || done_cnt[1] !== 1) begin failures++; $display("FAIL freeze_resume got=rd%0d done%0d want=rd16 done1", rd_cnt[1], done_cnt[1]); end
  endtask

  task automatic test_random();
    clear_stats();
    en_pct = 80;
    for (int k = 0; k < 3; k++) begin
      pqa.push_back(mk(2'($urandom), 20'($urandom), 4'($urandom), {$urandom, $urandom}));
      pqb.push_back(mk(2'($urandom), 20'($urandom), 4'($urandom), {$urandom, $urandom}));
    end
    drive_reqs();
    run_until_idle(4000, "random");
    checks++;
    if (done_cnt[0] + done_cnt[1] != 6) begin failures++; $display("FAIL random_done got=%0d want=6", done_cnt[0] + done_cnt[1]); end
    en_pct = 100;
  endtask

  initial begin
    i_reset = 1'b0; i_clk_en = 1'b1; i_phases = 4'b0001; i_bus_nibble_in = 4'h0;
    model_reset();
    clear_stats();
    drive_reqs();
    test_reset();
    test_load_read();
    test_arbitration();
    test_write_b();
    test_long_read();
    test_reset_mid();
    test_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
